operand_forward_unit: RTL and testbench
=======================================

# operand_forward_unit

Datapath-side forwarding and hazard unit for the 5-stage pipeline. It consumes decode-stage operand tags and tracks destination tags of in-flight instructions in a private EX/MEM/WB scoreboard. It produces registered operand-mux selects for the EX stage and a combinational load-use stall. A pipeline-fill state machine reports when all three downstream stages hold tracked entries.

## Interface
Parameters:
- REG_AW, 3, register-address width (8 architectural registers)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state when 0
- advance  in  1  pipeline moves this cycle (1 = shift)
- flush  in  1  synchronous; invalidates the scoreboard and returns the FSM to FILL1
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2  in  REG_AW  decode source registers
- id_use1, id_use2  in  1  source actually read
- id_we  in  1  decode instruction writes rd
- id_rd  in  REG_AW  decode destination
- id_is_load  in  1  decode instruction is a memory load
- fwd_a_sel, fwd_b_sel  out  2  EX operand A/B mux select
- stall  out  1  load-use hazard; hold IF/ID and inject a bubble
- pipe_full  out  1  FSM in RUN

## Operation
- Scoreboard has three slots: S_EX, S_MEM, S_WB. Each slot holds {valid, we, rd, is_load}. The write-capable predicate is W(slot) = valid & we.
- Shift when advance=1 and flush=0:
  - S_WB←S_MEM, S_MEM←S_EX.
  - S_EX←ID fields if stall=0 and id_valid=1; otherwise S_EX←bubble (valid=0).
- advance=0: all slots, selects and FSM hold.
- flush=1: all valid bits clear, selects go to 00, FSM goes to FILL1. flush has priority over advance.
- Select encoding:
  - 00 register file
  - 01 EX/MEM result (S_EX match at decode time)
  - 10 MEM/WB result (S_MEM match)
  - 11 WB buffer (S_WB match)
- Select computation for operand A: the youngest match wins (S_EX > S_MEM > S_WB). A match requires id_use1 & W(slot) & rd==id_rs1. Operand B uses the same rule with rs2/use2.
- Selects latch on the same shift that moves the instruction into S_EX. A bubble latches 00.
- stall = id_valid & S_EX.valid & S_EX.is_load & S_EX.we & ((id_use1 & rd==id_rs1) | (id_use2 & rd==id_rs2)).
- stall is combinational and is independent of advance.
- After a stalled shift, the load sits in S_MEM. The retried instruction then latches select 10.
- Fill FSM states: FILL1→FILL2→FILL3→RUN.
  - It steps one state per shift cycle with a valid S_EX input.
  - RUN is absorbing until flush or reset.
  - pipe_full=1 only in RUN.
  - Bubbles do not advance the FSM.

## Timing
- Reset values: fwd_a_sel=00, fwd_b_sel=00, pipe_full=0, scoreboard invalid, FSM=FILL1. stall=0 follows because every scoreboard slot is invalid.
- Select latency: 1 cycle. Selects are valid in the first cycle the instruction occupies EX and remain stable while advance=0.
- stall reflects the current ID/S_EX contents within the same cycle and deasserts in the cycle after the bubble shift.
- pipe_full rises in the cycle after the third valid shift.
- Asserting reset mid-operation clears everything immediately. There is no partial recovery.

## Configuration
- ZERO_REG_EN defined:
  - Register 0 is hardwired zero. A rd of 0 never matches, so selects for rs=0 are always 00 and there is no stall on rd=0.
  - Stall on rd=0 is suppressed as well.
- ZERO_REG_EN undefined: register 0 is an ordinary register and forwards like any other.

## Structure
- Shared package (pipeline pkg):
  - select-code localparams FWD_RF/FWD_EXMEM/FWD_MEMWB/FWD_WB.
  - FSM state encodings (3-bit, FILL1..RUN).
  - Scoreboard-entry field layout.
- One sub-module: fwd_match. It is purely combinational. Its inputs are one source tag plus the three slots; its outputs are the 2-bit select. It is instantiated twice, once for A and once for B.

## Test plan
- Reset, then issue ADD r1←r2,r3 followed by SUB r4←r1,r1 with advance=1 each cycle → SUB latches fwd_a_sel=fwd_b_sel=01. pipe_full stays 0 until the third valid shift.
- Writer to r5, then two independent instructions, then a reader of r5 on rs2 → fwd_b_sel=11, fwd_a_sel=00. Repeat with one independent instruction → fwd_b_sel=10.
- Two back-to-back writes to r2, then a reader of r2 → select 01 (youngest wins), not 10.
- LOAD r3, then ADD r6←r3,r1 → stall=1 for exactly one cycle and a bubble enters S_EX. The retried ADD latches fwd_a_sel=10.
- Mid-stream flush=1 with advance=1 → selects 00, pipe_full 0, and a subsequent reader of a pre-flush rd gets 00. Pulse reset low mid-stream → all outputs return to reset values asynchronously.
- With ZERO_REG_EN: write r0 then read r0 → selects 00, no stall for LOAD r0. Without ZERO_REG_EN → select 01 and stall asserted.

Source files
------------

// File: rtl/operand_forward_unit_pkg.sv
// Shared types for the EX operand forwarding unit.
// ZERO_REG_EN: register 0 is hardwired zero and never forwards.
package operand_forward_unit_pkg;

  localparam int RF_AW = 3;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  typedef enum logic [2:0] {
    FILL1 = 3'd0,
    FILL2 = 3'd1,
    FILL3 = 3'd2,
    RUN   = 3'd3
  } fill_state_e;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [RF_AW-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  function automatic logic sb_hit(
    input sb_entry_t        e,
    input logic [RF_AW-1:0] rs
  );
`ifdef ZERO_REG_EN
    return e.valid & e.we & (e.rd == rs) & (rs != '0);
`else
    return e.valid & e.we & (e.rd == rs);
`endif
  endfunction

endpackage

// File: rtl/operand_forward_unit_fwd_match.sv
// Per-operand forward select: youngest in-flight writer wins.
// ZERO_REG_EN: register 0 never matches.
module fwd_match
  import operand_forward_unit_pkg::*;
(
  input  logic             use_i,
  input  logic [RF_AW-1:0] rs_i,
  input  sb_entry_t        ex_i,
  input  sb_entry_t        mem_i,
  input  sb_entry_t        wb_i,
  output logic [1:0]       sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (use_i) begin
      if (sb_hit(ex_i, rs_i))
        sel_o = FWD_EXMEM;
      else if (sb_hit(mem_i, rs_i))
        sel_o = FWD_MEMWB;
      else if (sb_hit(wb_i, rs_i))
        sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_forward_unit.sv
// Forwarding/hazard unit: EX/MEM/WB scoreboard, registered selects.
// ZERO_REG_EN: register 0 never forwards nor stalls.
module operand_forward_unit
  import operand_forward_unit_pkg::*;
#(
  parameter int REG_AW = RF_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              pipe_full
);

  sb_entry_t   ex_q, mem_q, wb_q;
  sb_entry_t   ex_d, mem_d, wb_d;
  sb_entry_t   id_ent;
  logic [1:0]  sel_a_q, sel_a_d;
  logic [1:0]  sel_b_q, sel_b_d;
  logic [1:0]  m_a, m_b;
  fill_state_e st_q, st_d;
  logic        ld_ex, hit1, hit2, take;

  fwd_match u_match_a (
    .use_i (id_use1),
    .rs_i  (id_rs1),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (m_a)
  );

  fwd_match u_match_b (
    .use_i (id_use2),
    .rs_i  (id_rs2),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (m_b)
  );

  always_comb begin
    ld_ex = ex_q.valid & ex_q.we & ex_q.is_load;
`ifdef ZERO_REG_EN
    ld_ex = ld_ex & (ex_q.rd != '0);
`endif
    hit1  = id_use1 & (ex_q.rd == id_rs1);
    hit2  = id_use2 & (ex_q.rd == id_rs2);
    stall = id_valid & ld_ex & (hit1 | hit2);
    take  = id_valid & ~stall;
  end

  always_comb begin
    id_ent.valid   = take;
    id_ent.we      = id_we;
    id_ent.rd      = id_rd;
    id_ent.is_load = id_is_load;
  end

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    st_d    = st_q;
    if (flush) begin
      ex_d    = SB_BUBBLE;
      mem_d   = SB_BUBBLE;
      wb_d    = SB_BUBBLE;
      sel_a_d = FWD_RF;
      sel_b_d = FWD_RF;
      st_d    = FILL1;
    end else if (advance) begin
      wb_d    = mem_q;
      mem_d   = ex_q;
      ex_d    = take ? id_ent : SB_BUBBLE;
      sel_a_d = take ? m_a : FWD_RF;
      sel_b_d = take ? m_b : FWD_RF;
      if (take) begin
        unique case (st_q)
          FILL1:   st_d = FILL2;
          FILL2:   st_d = FILL3;
          FILL3:   st_d = RUN;
          default: st_d = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q    <= SB_BUBBLE;
      mem_q   <= SB_BUBBLE;
      wb_q    <= SB_BUBBLE;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
      st_q    <= FILL1;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      st_q    <= st_d;
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;
  assign pipe_full = (st_q == RUN);

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed bench for operand_forward_unit.
// Build with +define+ZERO_REG_EN to cover the hardwired-zero variant.
module tb_operand_forward_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       advance = 1'b1;
  logic       flush = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] id_rs1 = '0;
  logic [2:0] id_rs2 = '0;
  logic       id_use1 = 1'b0;
  logic       id_use2 = 1'b0;
  logic       id_we = 1'b0;
  logic [2:0] id_rd = '0;
  logic       id_is_load = 1'b0;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
  logic       pipe_full;

  int checks = 0;
  int errors = 0;

  operand_forward_unit dut (
    .clk        (clk),
    .reset      (reset),
    .advance    (advance),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use1    (id_use1),
    .id_use2    (id_use2),
    .id_we      (id_we),
    .id_rd      (id_rd),
    .id_is_load (id_is_load),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall      (stall),
    .pipe_full  (pipe_full)
  );

  always #5 clk = ~clk;

  task automatic drv(
    input logic       v,
    input logic [2:0] rs1,
    input logic       u1,
    input logic [2:0] rs2,
    input logic       u2,
    input logic       we,
    input logic [2:0] rd,
    input logic       ld
  );
    id_valid   = v;
    id_rs1     = rs1;
    id_use1    = u1;
    id_rs2     = rs2;
    id_use2    = u2;
    id_we      = we;
    id_rd      = rd;
    id_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drv(1, 3'd1, 1, 3'd2, 1, 1, 3'd1, 1);
    repeat (2) tick();
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_sel got %b/%b want 00/00", fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (pipe_full !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got full=%b stall=%b want 0/0", pipe_full, stall);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drv(1, 3'd2, 1, 3'd3, 1, 1, 3'd1, 0);
    tick();
    checks++;
    if (fwd_a_sel !== 2'b00 || pipe_full !== 1'b0) begin
      errors++;
      $display("FAIL basic_add got a=%b full=%b want 00/0", fwd_a_sel, pipe_full);
    end
    drv(1, 3'd1, 1, 3'd1, 1, 1, 3'd4, 0);
    tick();
    checks++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
      errors++;
      $display("FAIL basic_sub got %b/%b want 01/01", fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (pipe_full !== 1'b0) begin
      errors++;
      $display("FAIL basic_full2 got %b want 0", pipe_full);
    end
    drv(1, 0, 0, 0, 0, 1, 3'd7, 0);
    tick();
    checks++;
    if (pipe_full !== 1'b1) begin
      errors++;
      $display("FAIL basic_full3 got %b want 1", pipe_full);
    end
  endtask

  task automatic test_distance();
    drv(1, 0, 0, 0, 0, 1, 3'd5, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 3'd6, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 3'd7, 0); tick();
    drv(1, 3'd2, 1, 3'd5, 1, 0, 3'd0, 0); tick();
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b11) begin
      errors++;
      $display("FAIL dist_wb got %b/%b want 00/11", fwd_a_sel, fwd_b_sel);
    end
    drv(1, 0, 0, 0, 0, 1, 3'd5, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 3'd6, 0); tick();
    drv(1, 3'd2, 1, 3'd5, 1, 0, 3'd0, 0); tick();
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10) begin
      errors++;
      $display("FAIL dist_mem got %b/%b want 00/10", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_youngest();
    drv(1, 0, 0, 0, 0, 1, 3'd2, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 3'd2, 0); tick();
    drv(1, 3'd2, 1, 3'd2, 1, 0, 3'd0, 0); tick();
    checks++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
      errors++;
      $display("FAIL youngest got %b/%b want 01/01", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_load_use();
    drv(1, 0, 0, 0, 0, 1, 3'd3, 1); tick();
    drv(1, 3'd3, 1, 3'd1, 1, 1, 3'd6, 0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b want 1", stall);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || fwd_a_sel !== 2'b00) begin
      errors++;
      $display("FAIL lu_bubble got stall=%b a=%b want 0/00", stall, fwd_a_sel);
    end
    tick();
    checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL lu_retry got %b/%b want 10/00", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_hold();
    drv(1, 0, 0, 0, 0, 1, 3'd1, 0); tick();
    drv(1, 3'd1, 1, 0, 0, 0, 3'd0, 0); tick();
    advance = 1'b0;
    drv(1, 0, 0, 3'd1, 1, 0, 3'd0, 0);
    repeat (2) tick();
    checks++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL hold got %b/%b want 01/00", fwd_a_sel, fwd_b_sel);
    end
    advance = 1'b1;
  endtask

  task automatic test_flush();
    drv(1, 0, 0, 0, 0, 1, 3'd4, 0); tick();
    drv(1, 3'd4, 1, 0, 0, 0, 3'd0, 0); tick();
    checks++;
    if (fwd_a_sel !== 2'b01) begin
      errors++;
      $display("FAIL flush_pre got %b want 01", fwd_a_sel);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (fwd_a_sel !== 2'b00 || pipe_full !== 1'b0) begin
      errors++;
      $display("FAIL flush got a=%b full=%b want 00/0", fwd_a_sel, pipe_full);
    end
    tick();
    checks++;
    if (fwd_a_sel !== 2'b00) begin
      errors++;
      $display("FAIL flush_post got %b want 00", fwd_a_sel);
    end
  endtask

  task automatic test_async_reset();
    drv(1, 0, 0, 0, 0, 1, 3'd1, 0); tick();
    drv(1, 3'd1, 1, 0, 0, 1, 3'd2, 1); tick();
    checks++;
    if (fwd_a_sel !== 2'b01 || pipe_full !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got a=%b full=%b want 01/1", fwd_a_sel, pipe_full);
    end
    drv(1, 3'd2, 1, 0, 0, 0, 3'd0, 0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL ar_stall_pre got %b want 1", stall);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (fwd_a_sel !== 2'b00 || pipe_full !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL ar_clear got a=%b full=%b stall=%b want 00/0/0",
               fwd_a_sel, pipe_full, stall);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero_reg();
    logic [1:0] exp_sel;
    logic       exp_stall;
`ifdef ZERO_REG_EN
    exp_sel   = 2'b00;
    exp_stall = 1'b0;
`else
    exp_sel   = 2'b01;
    exp_stall = 1'b1;
`endif
    drv(1, 0, 0, 0, 0, 1, 3'd0, 0); tick();
    drv(1, 3'd0, 1, 3'd0, 1, 0, 3'd0, 0); tick();
    checks++;
    if (fwd_a_sel !== exp_sel || fwd_b_sel !== exp_sel) begin
      errors++;
      $display("FAIL zero_sel got %b/%b want %b", fwd_a_sel, fwd_b_sel, exp_sel);
    end
    drv(1, 0, 0, 0, 0, 1, 3'd0, 1); tick();
    drv(1, 3'd0, 1, 0, 0, 0, 3'd0, 0);
    #1;
    checks++;
    if (stall !== exp_stall) begin
      errors++;
      $display("FAIL zero_stall got %b want %b", stall, exp_stall);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_distance();
    test_youngest();
    test_load_use();
    test_hold();
    test_flush();
    test_async_reset();
    test_zero_reg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
